// File: rtl/ctrl_teclado_decimal_pkg.sv
// Shared definitions for the decimal keypad controller: FSM states,
// BCD width and the one-hot to BCD encoder.
package ctrl_teclado_decimal_pkg;

    localparam int BCD_W   = 4;
    localparam int NTECLAS = 10;

    typedef enum logic [1:0] {
        REPOSO       = 2'd0,
        ANTIRREBOTE  = 2'd1,
        EMITIR       = 2'd2,
        ESPERA_LIBRE = 2'd3
    } estado_t;

    // Index of the set line as a BCD code; only meaningful for one-hot input.
    function automatic logic [BCD_W-1:0] onehot_a_bcd(input logic [NTECLAS-1:0] v);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NTECLAS; i++) begin
            if (v[i]) begin
                r = BCD_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ctrl_teclado_decimal_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous input lines.
module sincronizador_2ff #(
    parameter int ANCHO = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);

    logic [ANCHO-1:0] etapa1;

    // Two back-to-back registers to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            etapa1 <= '0;
            q      <= '0;
        end else begin
            etapa1 <= d;
            q      <= etapa1;
        end
    end

endmodule

// File: rtl/ctrl_teclado_decimal.sv
// Decimal keypad controller: synchronise, reject multi-key, debounce press
// and release, offer the digit on valid/ready and shift it into the display.
module ctrl_teclado_decimal
    import ctrl_teclado_decimal_pkg::*;
#(
    parameter int DEB_CICLOS = 4,
    parameter int NDIG       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NTECLAS-1:0]        tecla,
    input  logic                      clr,
    output logic [BCD_W-1:0]          dig_bcd,
    output logic                      dig_valid,
    input  logic                      dig_ready,
    output logic [BCD_W*NDIG-1:0]     digitos,
    output logic [$clog2(NDIG+1)-1:0] n_dig,
    output logic                      err_multi
);

    localparam int CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
    localparam int NW = $clog2(NDIG+1);
    localparam logic [CW-1:0] CNT_FIN = CW'(DEB_CICLOS - 1);
    localparam logic [NW-1:0] N_MAX   = NW'(NDIG);

    logic [NTECLAS-1:0]    tecla_s;
    logic                  uno, ninguno, multi;
    logic [BCD_W-1:0]      cod;

    estado_t               estado, estado_nx;
    logic [BCD_W-1:0]      cand, cand_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  valid_nx, err_nx;
    logic [BCD_W-1:0]      bcd_nx;
    logic [BCD_W*NDIG-1:0] digitos_nx;
    logic [NW-1:0]         n_dig_nx;

    sincronizador_2ff #(
        .ANCHO(NTECLAS)
    ) u_sinc (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tecla),
        .q     (tecla_s)
    );

    assign uno     = $onehot(tecla_s);
    assign ninguno = (tecla_s == '0);
    assign multi   = !uno && !ninguno;
    assign cod     = onehot_a_bcd(tecla_s);

    // State, debounce counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= REPOSO;
            cand      <= '0;
            cnt       <= '0;
            dig_valid <= 1'b0;
            dig_bcd   <= '0;
            err_multi <= 1'b0;
            digitos   <= '0;
            n_dig     <= '0;
        end else begin
            estado    <= estado_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            dig_valid <= valid_nx;
            dig_bcd   <= bcd_nx;
            err_multi <= err_nx;
            digitos   <= digitos_nx;
            n_dig     <= n_dig_nx;
        end
    end

    // Next-state, debounce counting, handshake and display update.
    // dig_valid is produced registered together with the move into EMITIR,
    // so dig_valid high is equivalent to being in EMITIR.
    always_comb begin
        estado_nx  = estado;
        cand_nx    = cand;
        cnt_nx     = cnt;
        valid_nx   = dig_valid;
        bcd_nx     = dig_bcd;
        err_nx     = 1'b0;
        digitos_nx = digitos;
        n_dig_nx   = n_dig;

        case (estado)
            REPOSO: begin
                if (uno) begin
                    estado_nx = ANTIRREBOTE;
                    cand_nx   = cod;
                    cnt_nx    = '0;
                end else if (multi) begin
                    estado_nx = ESPERA_LIBRE;
                    cnt_nx    = '0;
                    err_nx    = 1'b1;
                end
            end
            ANTIRREBOTE: begin
                if (uno && (cod == cand)) begin
                    if (cnt == CNT_FIN) begin
                        estado_nx = EMITIR;
                        valid_nx  = 1'b1;
                        bcd_nx    = cand;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    estado_nx = REPOSO;
                end
            end
            EMITIR: begin
                if (dig_ready) begin
                    estado_nx = ESPERA_LIBRE;
                    valid_nx  = 1'b0;
                    cnt_nx    = '0;
                end
            end
            ESPERA_LIBRE: begin
                if (!ninguno) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_FIN) begin
                    estado_nx = REPOSO;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: estado_nx = REPOSO;
        endcase

        // clr takes priority over a coinciding handshake.
        if (clr) begin
            digitos_nx = '0;
            n_dig_nx   = '0;
        end else if (dig_valid && dig_ready) begin
            for (int unsigned i = NDIG - 1; i > 0; i--) begin
                digitos_nx[BCD_W*i +: BCD_W] = digitos[BCD_W*(i-1) +: BCD_W];
            end
            digitos_nx[BCD_W-1:0] = cand;
            if (n_dig != N_MAX) begin
                n_dig_nx = n_dig + 1'b1;
            end
        end
    end

endmodule
